// File: rtl/CSR_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : CSR_pkg
//  Description : Shared widths, CSR address map, bit indices and FSM state
//                encoding for the machine-mode CSR unit.
//  Revision    : 1.0  initial release
// ============================================================================
package CSR_pkg;

    localparam int CSR_DATA_WIDTH = 32;
    localparam int CSR_ADDR_WIDTH = 12;

    // CSR address map
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MINSTRETH = 12'hB82;

    // Bit positions inside mstatus / mie / mip
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTIE_BIT = 7;
    localparam int MEIE_BIT = 11;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WFI  = 2'd1,
        TRAP = 2'd2
    } csr_state_t;

endpackage
`default_nettype wire

// File: rtl/CSR_ctrl_intf.sv
`default_nettype none
// ============================================================================
//  Module      : CSR_ctrl_intf
//  Description : CPU <-> CSR unit control interface. The CPU drives the cpu
//                modport, the CSR unit consumes the register modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface CSR_ctrl_intf;
    import CSR_pkg::*;

    logic [CSR_DATA_WIDTH-1:0] CSR_wdata;
    logic [CSR_ADDR_WIDTH-1:0] CSR_addr;
    logic                      CSR_wait;
    logic                      CSR_ret;
    logic                      CSR_write;
    logic [CSR_DATA_WIDTH-1:0] curr_pc;
    logic [CSR_DATA_WIDTH-1:0] CSR_rdata;
    logic [CSR_DATA_WIDTH-1:0] CSR_ret_PC;
    logic [CSR_DATA_WIDTH-1:0] CSR_ISR_PC;

    modport cpu (
        output CSR_wdata, CSR_addr, CSR_wait, CSR_ret, CSR_write, curr_pc,
        input  CSR_rdata, CSR_ret_PC, CSR_ISR_PC
    );

    modport register (
        input  CSR_wdata, CSR_addr, CSR_wait, CSR_ret, CSR_write, curr_pc,
        output CSR_rdata, CSR_ret_PC, CSR_ISR_PC
    );

endinterface
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit free/enabled counter kept as two 32-bit halves so the
//                CSR read mux can pick lo/hi directly. Carry into the high
//                half happens in the same cycle the low half wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [31:0] lo_q;
    logic [31:0] hi_q;

    // Increment low half; bump high half when the low half rolls over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= 32'd0;
            hi_q <= 32'd0;
        end else if (inc_i) begin
            lo_q <= lo_q + 32'd1;
            if (lo_q == 32'hFFFF_FFFF) begin
                hi_q <= hi_q + 32'd1;
            end
        end
    end

    assign lo_o = lo_q;
    assign hi_o = hi_q;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_unit
//  Description : Machine-mode CSR file (mstatus/mie/mip/mtvec/mepc, 64-bit
//                mcycle/minstret) plus the RUN/WFI/TRAP interrupt sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module csr_unit
    import CSR_pkg::*;
#(
    parameter logic [CSR_DATA_WIDTH-1:0] MTVEC_RESET = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    CSR_ctrl_intf.register        csr_if,
    input  logic                  ext_irq,
    input  logic                  timer_irq,
    input  logic                  stall,
    input  logic                  instr_retire,
    output logic                  trap_taken
);

    csr_state_t                state_q, state_d;

    logic                      mstatus_mie_q;
    logic                      mstatus_mpie_q;
    logic                      mie_meie_q;
    logic                      mie_mtie_q;
    logic                      mip_meip_q;
    logic                      mip_mtip_q;
    logic [CSR_DATA_WIDTH-1:0] mepc_q;
    logic [CSR_DATA_WIDTH-1:0] wfi_pc_q;

    logic [31:0]               w_mcycle_lo, w_mcycle_hi;
    logic [31:0]               w_minstret_lo, w_minstret_hi;

    logic                      w_pending;
    logic                      w_trap_commit;
    logic [CSR_DATA_WIDTH-1:0] w_trap_target;
    logic                      w_wfi_latch;
    logic                      w_mret;

    logic                      w_wr_mstatus;
    logic                      w_wr_mie;
    logic                      w_wr_mepc;

    logic [CSR_DATA_WIDTH-1:0] w_mstatus;
    logic [CSR_DATA_WIDTH-1:0] w_mie;
    logic [CSR_DATA_WIDTH-1:0] w_mip;

    assign w_wr_mstatus = csr_if.CSR_write && (csr_if.CSR_addr == CSR_MSTATUS);
    assign w_wr_mie     = csr_if.CSR_write && (csr_if.CSR_addr == CSR_MIE);
    assign w_wr_mepc    = csr_if.CSR_write && (csr_if.CSR_addr == CSR_MEPC);

    // Registered mip means an irq needs at least one cycle to become pending.
    assign w_pending = mstatus_mie_q &
                       ((mie_meie_q & mip_meip_q) | (mie_mtie_q & mip_mtip_q));

    // Assemble architectural views; MPP is hardwired to machine mode.
    always_comb begin
        w_mstatus           = 32'd0;
        w_mstatus[12:11]    = 2'b11;
        w_mstatus[MIE_BIT]  = mstatus_mie_q;
        w_mstatus[MPIE_BIT] = mstatus_mpie_q;
        w_mie               = 32'd0;
        w_mie[MEIE_BIT]     = mie_meie_q;
        w_mie[MTIE_BIT]     = mie_mtie_q;
        w_mip               = 32'd0;
        w_mip[MEIE_BIT]     = mip_meip_q;
        w_mip[MTIE_BIT]     = mip_mtip_q;
    end

    // Zero-latency read mux; unmapped addresses read as zero.
    always_comb begin
        case (csr_if.CSR_addr)
            CSR_MSTATUS:   csr_if.CSR_rdata = w_mstatus;
            CSR_MIE:       csr_if.CSR_rdata = w_mie;
            CSR_MTVEC:     csr_if.CSR_rdata = MTVEC_RESET;
            CSR_MEPC:      csr_if.CSR_rdata = mepc_q;
            CSR_MIP:       csr_if.CSR_rdata = w_mip;
            CSR_MCYCLE:    csr_if.CSR_rdata = w_mcycle_lo;
            CSR_MCYCLEH:   csr_if.CSR_rdata = w_mcycle_hi;
            CSR_MINSTRET:  csr_if.CSR_rdata = w_minstret_lo;
            CSR_MINSTRETH: csr_if.CSR_rdata = w_minstret_hi;
            default:       csr_if.CSR_rdata = 32'd0;
        endcase
    end

    assign csr_if.CSR_ISR_PC = MTVEC_RESET;
    assign csr_if.CSR_ret_PC = mepc_q;
    assign trap_taken        = (state_q == TRAP);

    // Next-state logic: MRET outranks both WFI entry and interrupts.
    always_comb begin
        state_d       = state_q;
        w_trap_commit = 1'b0;
        w_trap_target = 32'd0;
        w_wfi_latch   = 1'b0;
        w_mret        = 1'b0;
        case (state_q)
            RUN: begin
                if (csr_if.CSR_ret) begin
                    w_mret = 1'b1;
                end else if (csr_if.CSR_wait) begin
                    if (w_pending) begin
                        state_d       = TRAP;
                        w_trap_commit = 1'b1;
                        w_trap_target = csr_if.curr_pc + 32'd4;
                    end else begin
                        state_d     = WFI;
                        w_wfi_latch = 1'b1;
                    end
                end else if (w_pending && !stall) begin
                    state_d       = TRAP;
                    w_trap_commit = 1'b1;
                    w_trap_target = csr_if.curr_pc;
                end
            end
            WFI: begin
                if (w_pending) begin
                    state_d       = TRAP;
                    w_trap_commit = 1'b1;
                    w_trap_target = wfi_pc_q + 32'd4;
                end
            end
            TRAP: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // mstatus / mepc: trap commit beats MRET, which beats a software write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mepc_q         <= 32'd0;
        end else if (w_trap_commit) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            mepc_q         <= {w_trap_target[31:2], 2'b00};
        end else begin
            if (w_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (w_wr_mstatus) begin
                mstatus_mie_q  <= csr_if.CSR_wdata[MIE_BIT];
                mstatus_mpie_q <= csr_if.CSR_wdata[MPIE_BIT];
            end
            if (w_wr_mepc) begin
                mepc_q <= {csr_if.CSR_wdata[31:2], 2'b00};
            end
        end
    end

    // mie enables, mip sampling and the WFI resume PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_meie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mip_meip_q <= 1'b0;
            mip_mtip_q <= 1'b0;
            wfi_pc_q   <= 32'd0;
        end else begin
            if (w_wr_mie) begin
                mie_meie_q <= csr_if.CSR_wdata[MEIE_BIT];
                mie_mtie_q <= csr_if.CSR_wdata[MTIE_BIT];
            end
            mip_meip_q <= ext_irq;
            mip_mtip_q <= timer_irq;
            if (w_wfi_latch) begin
                wfi_pc_q <= csr_if.curr_pc;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc_i (1'b1),
        .lo_o  (w_mcycle_lo),
        .hi_o  (w_mcycle_hi)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc_i (instr_retire),
        .lo_o  (w_minstret_lo),
        .hi_o  (w_minstret_hi)
    );

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_unit
//  Description : Directed, table-driven bench for csr_unit with hand-written
//                sequences for WFI, MRET, stall, priority and counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csr_unit;
    import CSR_pkg::*;

    logic clk;
    logic rst;
    logic ext_irq;
    logic timer_irq;
    logic stall;
    logic instr_retire;
    logic trap_taken;

    int n_checks;
    int n_errors;

    CSR_ctrl_intf ifc ();

    csr_unit dut (
        .clk          (clk),
        .rst          (rst),
        .csr_if       (ifc.register),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .stall        (stall),
        .instr_retire (instr_retire),
        .trap_taken   (trap_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        ifc.CSR_addr = a;
        #1;
        d = ifc.CSR_rdata;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        ifc.CSR_addr  = a;
        ifc.CSR_wdata = d;
        ifc.CSR_write = 1'b1;
        @(posedge clk);
        #1;
        ifc.CSR_write = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{1'b0, 12'h300, 32'h0,         32'h0000_1800};
        vecs[1]  = '{1'b0, 12'h304, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 12'h305, 32'h0,         32'h0001_0000};
        vecs[3]  = '{1'b0, 12'h341, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b0, 12'h344, 32'h0,         32'h0000_0000};
        vecs[5]  = '{1'b0, 12'h123, 32'h0,         32'h0000_0000};
        vecs[6]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
        vecs[7]  = '{1'b1, 12'h341, 32'h0000_1237, 32'h0000_1234};
        vecs[8]  = '{1'b1, 12'h305, 32'h0000_0000, 32'h0001_0000};
        vecs[9]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 32'h0000_0880};
        vecs[10] = '{1'b1, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[11] = '{1'b1, 12'h123, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{1'b1, 12'h300, 32'h0000_0000, 32'h0000_1800};
        vecs[13] = '{1'b1, 12'h304, 32'h0000_0000, 32'h0000_0000};
        vecs[14] = '{1'b1, 12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC};

        rst           = 1'b1;
        ext_irq       = 1'b0;
        timer_irq     = 1'b0;
        stall         = 1'b0;
        instr_retire  = 1'b0;
        ifc.CSR_wdata = 32'd0;
        ifc.CSR_addr  = 12'd0;
        ifc.CSR_wait  = 1'b0;
        ifc.CSR_ret   = 1'b0;
        ifc.CSR_write = 1'b0;
        ifc.curr_pc   = 32'd0;
        #1;
        chk("reset_trap_taken", {31'd0, trap_taken}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Register map and write masks
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end
            rd_chk($sformatf("tbl%0d_addr%h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end

        // WFI entry then external interrupt wake-up
        wr(CSR_MSTATUS, 32'h8);
        wr(CSR_MIE, 32'h800);
        @(negedge clk);
        ifc.CSR_wait = 1'b1;
        ifc.curr_pc  = 32'h200;
        tick();
        ifc.CSR_wait = 1'b0;
        chk("wfi_enter_state", {30'd0, dut.state_q}, {30'd0, WFI});
        @(negedge clk);
        ext_irq = 1'b1;
        tick();
        chk("wfi_irq_latency", {31'd0, trap_taken}, 32'd0);
        tick();
        chk("wfi_trap_taken", {31'd0, trap_taken}, 32'd1);
        rd_chk("wfi_mepc", CSR_MEPC, 32'h204);
        rd_chk("wfi_mstatus", CSR_MSTATUS, 32'h1880);
        chk("isr_pc", ifc.CSR_ISR_PC, 32'h0001_0000);
        @(negedge clk);
        ext_irq = 1'b0;
        tick();
        chk("trap_one_cycle", {31'd0, trap_taken}, 32'd0);

        // MRET
        @(negedge clk);
        ifc.CSR_ret = 1'b1;
        #1;
        chk("mret_ret_pc", ifc.CSR_ret_PC, 32'h204);
        tick();
        ifc.CSR_ret = 1'b0;
        rd_chk("mret_mstatus", CSR_MSTATUS, 32'h1888);

        // CSR_ret outranks a pending interrupt
        @(negedge clk);
        stall   = 1'b1;
        ext_irq = 1'b1;
        tick();
        tick();
        chk("stall_blocks_ext", {31'd0, trap_taken}, 32'd0);
        @(negedge clk);
        ifc.CSR_ret = 1'b1;
        stall       = 1'b0;
        ifc.curr_pc = 32'h400;
        tick();
        ifc.CSR_ret = 1'b0;
        chk("ret_beats_irq", {31'd0, trap_taken}, 32'd0);
        tick();
        chk("trap_after_ret", {31'd0, trap_taken}, 32'd1);
        rd_chk("trap_after_ret_mepc", CSR_MEPC, 32'h400);
        @(negedge clk);
        ext_irq = 1'b0;
        tick();

        // Timer interrupt held off by stall; trap beats same-cycle mepc write
        wr(CSR_MSTATUS, 32'h8);
        wr(CSR_MIE, 32'h80);
        @(negedge clk);
        stall     = 1'b1;
        timer_irq = 1'b1;
        tick();
        tick();
        chk("stall_blocks_timer", {31'd0, trap_taken}, 32'd0);
        @(negedge clk);
        stall         = 1'b0;
        ifc.curr_pc   = 32'h300;
        ifc.CSR_addr  = CSR_MEPC;
        ifc.CSR_wdata = 32'h40;
        ifc.CSR_write = 1'b1;
        tick();
        ifc.CSR_write = 1'b0;
        timer_irq     = 1'b0;
        chk("timer_trap_taken", {31'd0, trap_taken}, 32'd1);
        rd_chk("trap_beats_write", CSR_MEPC, 32'h300);
        rd_chk("timer_mstatus", CSR_MSTATUS, 32'h1880);
        tick();

        // minstret counting
        @(negedge clk);
        instr_retire = 1'b1;
        tick();
        tick();
        tick();
        instr_retire = 1'b0;
        rd_chk("minstret_lo", CSR_MINSTRET, 32'd3);
        rd_chk("minstret_hi", CSR_MINSTRETH, 32'd0);

        // minstret full 64-bit wrap
        @(negedge clk);
        force dut.u_minstret.lo_q = 32'hFFFF_FFFF;
        force dut.u_minstret.hi_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_minstret.lo_q;
        release dut.u_minstret.hi_q;
        instr_retire = 1'b1;
        tick();
        instr_retire = 1'b0;
        rd_chk("minstret_wrap_lo", CSR_MINSTRET, 32'd0);
        rd_chk("minstret_wrap_hi", CSR_MINSTRETH, 32'd0);

        // mcycle carry into the high word
        @(negedge clk);
        force dut.u_mcycle.lo_q = 32'hFFFF_FFFF;
        force dut.u_mcycle.hi_q = 32'h0;
        #1;
        release dut.u_mcycle.lo_q;
        release dut.u_mcycle.hi_q;
        tick();
        rd_chk("mcycle_carry_hi", CSR_MCYCLEH, 32'd1);
        rd_chk("mcycle_carry_lo", CSR_MCYCLE, 32'd0);

        // Asynchronous reset while parked in WFI
        @(negedge clk);
        ifc.CSR_wait = 1'b1;
        ifc.curr_pc  = 32'h500;
        tick();
        ifc.CSR_wait = 1'b0;
        chk("wfi2_state", {30'd0, dut.state_q}, {30'd0, WFI});
        rst = 1'b1;
        #1;
        chk("rst_state", {30'd0, dut.state_q}, {30'd0, RUN});
        chk("rst_trap_taken", {31'd0, trap_taken}, 32'd0);
        rd_chk("rst_mstatus", CSR_MSTATUS, 32'h1800);
        rd_chk("rst_mie", CSR_MIE, 32'h0);
        rd_chk("rst_mepc", CSR_MEPC, 32'h0);
        rd_chk("rst_mcycle", CSR_MCYCLE, 32'h0);
        rd_chk("rst_minstret", CSR_MINSTRET, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_state", {30'd0, dut.state_q}, {30'd0, RUN});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
